// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction-fetch front end
//   WIDTH          default address/instruction width
//   RESET_PC       default PC loaded on reset
//   PC_STEP        sequential fetch increment
//   PC_READ_OFFSET ARM R15 read offset relative to the instruction address
package fetch_pkg;
    localparam int          WIDTH          = 32;
    localparam logic [31:0] RESET_PC       = 32'h0;
    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;
endpackage

// File: rtl/adder.sv
// adder: combinational modulo-2^WIDTH adder
//   a, b  operands
//   sum   a + b, carry discarded
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry circular FIFO of {pc, instr} with flush
//   clk, reset            clock, synchronous active-high reset
//   flush                 empty the queue (wins over push/pop)
//   push, push_pc/instr   write an entry at the tail
//   pop                   drop the head entry (caller only pops when count != 0)
//   count                 number of valid entries
//   head_pc, head_instr   entry at the head
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int WIDTH = fetch_pkg::WIDTH,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_pc,
    input  logic [WIDTH-1:0] push_instr,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_pc,
    output logic [WIDTH-1:0] head_instr
);
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, synchronous imem driver and fetch queue feeding decode
//   clk, reset                 clock, synchronous active-high reset
//   redirect, redirect_pc      PC change from execute; flushes all fetched state
//   imem_en, imem_addr         read request and word-aligned address (= pc)
//   imem_rdata                 instruction, valid the cycle after imem_en
//   out_valid, out_ready       decode handshake
//   out_instr, out_pc          queue head and its address
//   out_pc_plus8               out_pc + 8 (R15 read value)
module fetch_unit #(
    parameter int               WIDTH    = fetch_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(fetch_pkg::RESET_PC),
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_en,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus8
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] pc, pc_next, req_pc, head_pc;
    logic [CW-1:0]    count;
    logic             inflight, killed, issue, push, pop;
    logic             unused_low;

    assign unused_low = ^redirect_pc[1:0];

    assign pop       = out_valid & out_ready;
    // Each in-flight request owns a queue slot, so a full queue can never overflow.
    assign issue     = !reset && !redirect &&
                       (({1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop)) < (CW+1)'(DEPTH));
    // A response arriving in a flush cycle, or flagged after one, belongs to the old stream.
    assign push      = inflight && !killed && !redirect && !reset;
    assign imem_en   = issue;
    assign imem_addr = pc;
    assign out_valid = !reset && (count != '0);
    assign out_pc    = head_pc;

    adder #(.WIDTH(WIDTH)) u_pc_add (
        .a   (pc),
        .b   (WIDTH'(PC_STEP)),
        .sum (pc_next)
    );

    adder #(.WIDTH(WIDTH)) u_r15_add (
        .a   (head_pc),
        .b   (WIDTH'(PC_READ_OFFSET)),
        .sum (out_pc_plus8)
    );

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_pc    (req_pc),
        .push_instr (imem_rdata),
        .pop        (pop),
        .count      (count),
        .head_pc    (head_pc),
        .head_instr (out_instr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            killed   <= 1'b0;
        end else begin
            inflight <= issue;
            killed   <= redirect;
            if (redirect)
                pc <= {redirect_pc[WIDTH-1:2], 2'b00};
            else if (issue) begin
                pc     <= pc_next;
                req_pc <= pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a latency/order model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1, redirect = 1'b0, out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc_plus8;
    logic        b_imem_en, b_out_valid;
    logic [31:0] b_imem_addr, b_imem_rdata, b_out_instr, b_out_pc, b_out_pc_plus8;

    int vectors = 0, miscompares = 0;

    localparam logic [31:0] B_RESET = 32'hFFFF_FFF8;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus8(out_pc_plus8)
    );

    fetch_unit #(.RESET_PC(B_RESET)) dut_b (
        .clk(clk), .reset(reset), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_en(b_imem_en), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_instr(b_out_instr),
        .out_pc(b_out_pc), .out_pc_plus8(b_out_pc_plus8)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) begin
        imem_rdata   <= imem_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        b_imem_rdata <= b_imem_en ? mem_word(b_imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic        r1 = 1'b1, r2 = 1'b1, d1 = 1'b0, d2 = 1'b0;
    logic [31:0] fetch_pc, head_pc, b_fetch, b_head;

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic ev, en, bv;
        @(posedge clk);
        #1;
        reset = r; redirect = rd; redirect_pc = rpc; out_ready = rdy;
        #1;
        ev = !r && !r1 && !r2 && !d1 && !d2;
        en = !r && !rd && (!ev || rdy);
        check("out_valid", out_valid, ev);
        check("imem_en", imem_en, en);
        if (en) check("imem_addr", imem_addr, fetch_pc);
        if (ev) begin
            check("out_pc", out_pc, head_pc);
            check("out_instr", out_instr, mem_word(head_pc));
            check("out_pc_plus8", out_pc_plus8, head_pc + 32'd8);
        end
        bv = !r && !r1 && !r2;
        check("b_valid", b_out_valid, bv);
        check("b_imem_en", b_imem_en, !r);
        if (!r) check("b_imem_addr", b_imem_addr, b_fetch);
        if (bv) begin
            check("b_out_pc", b_out_pc, b_head);
            check("b_out_instr", b_out_instr, mem_word(b_head));
            check("b_out_pc_plus8", b_out_pc_plus8, b_head + 32'd8);
        end
        if (r) begin
            fetch_pc = 32'h0; head_pc = 32'h0;
            b_fetch = B_RESET; b_head = B_RESET;
        end else begin
            if (rd) begin
                fetch_pc = {rpc[31:2], 2'b00};
                head_pc  = {rpc[31:2], 2'b00};
            end else begin
                if (en) fetch_pc = fetch_pc + 32'd4;
                if (ev && rdy) head_pc = head_pc + 32'd4;
            end
            b_fetch = b_fetch + 32'd4;
            if (bv) b_head = b_head + 32'd4;
        end
        r2 = r1; r1 = r; d2 = d1; d1 = rd;
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (25) step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h103, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'hFFFF_FFF2, 1'b1);
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        step(1'b0, 1'b1, 32'h80, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h200, 1'b0);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (600)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 3) != 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
